// File: rtl/mux_scan_sequencer_if.sv
// Readout stream of the scan sequencer: one captured mux word tagged with its channel index.
interface mux_scan_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SELW  = 4
) ();
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0]  out_chan;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_chan, output out_valid, input out_ready);
    modport slave  (input out_data, input out_chan, input out_valid, output out_ready);
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scans the channels enabled in a mask through a registered channel mux, lowest index first,
// and streams each captured word out with its channel tag over a valid/ready handshake.
module mux_scan_sequencer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NCH       = 16,
    parameter int unsigned SELW      = 4,
    parameter int unsigned MUX_LAT   = 1,
    parameter int unsigned SKIP_ZERO = 0,
    parameter int unsigned CNTW      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NCH-1:0]       ch_mask_i,
    output logic [SELW-1:0]      mux_sel_o,
    input  logic [WIDTH-1:0]     mux_q_i,
    mux_scan_sequencer_if.master out_if,
    output logic                 busy_o,
    output logic                 scan_done_o,
    output logic [CNTW-1:0]      overrun_cnt_o
);
    localparam int unsigned     LATW     = (MUX_LAT < 2) ? 1 : $clog2(MUX_LAT + 1);
    localparam logic [LATW-1:0] LAT_LOAD = LATW'(MUX_LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NCH-1:0]   rem_q, rem_d;
    logic [LATW-1:0]  cnt_q, cnt_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  chan_q, chan_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNTW-1:0]  ovr_q, ovr_d;

    logic             hs_c;
    logic             skip_c;

    function automatic logic [SELW-1:0] lowest_idx(input logic [NCH-1:0] m);
        logic [SELW-1:0] idx;
        idx = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (m[i]) idx = SELW'(i);
        end
        return idx;
    endfunction

    // A skipped (zero) word leaves valid low, so OUT then exits as if handshaken.
    assign hs_c   = (state_q == ST_OUT) && (!valid_q || out_if.out_ready);
    assign skip_c = (SKIP_ZERO != 0) && (mux_q_i == '0);

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin : next_state_comb
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i && (ch_mask_i != '0)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort_i)              state_d = ST_IDLE;
                else if (cnt_q == '0)     state_d = ST_OUT;
            end
            ST_OUT: begin
                if (abort_i)              state_d = ST_IDLE;
                else if (hs_c)            state_d = (rem_q != '0) ? ST_WAIT : ST_IDLE;
            end
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin : output_comb
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    if (ch_mask_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d = lowest_idx(ch_mask_i);
                        rem_d = ch_mask_i & (ch_mask_i - NCH'(1));
                        cnt_d = LAT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    rem_d   = '0;
                    valid_d = 1'b0;
                end else if (cnt_q == '0) begin
                    data_d  = mux_q_i;
                    chan_d  = sel_q;
                    valid_d = !skip_c;
                end else begin
                    cnt_d = cnt_q - LATW'(1);
                end
            end
            ST_OUT: begin
                if (abort_i) begin
                    rem_d   = '0;
                    valid_d = 1'b0;
                end else if (hs_c) begin
                    valid_d = 1'b0;
                    if (rem_q != '0) begin
                        // rem & (rem-1) drops the lowest set bit, i.e. the channel just loaded
                        sel_d = lowest_idx(rem_q);
                        rem_d = rem_q & (rem_q - NCH'(1));
                        cnt_d = LAT_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                rem_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        if ((state_q != ST_IDLE) && start_i && !abort_i && (ovr_q != '1)) begin
            ovr_d = ovr_q + CNTW'(1);
        end
        busy_d = (state_d != ST_IDLE);
    end

    assign mux_sel_o        = sel_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_chan  = chan_q;
    assign out_if.out_valid = valid_q;
    assign busy_o           = busy_q;
    assign scan_done_o      = done_q;
    assign overrun_cnt_o    = ovr_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SKIP_ZERO=0/1) against a transaction-level model.
module tb_mux_scan_sequencer;
    localparam int unsigned MUX_LAT = 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] mask  = '0;
    logic        rdy0  = 1'b0;
    logic        rdy1  = 1'b0;
    logic [31:0] tbl [16];

    logic [3:0]  sel0, sel1;
    logic [31:0] q0 = '0, q1 = '0;
    logic        busy0, busy1, done0, done1;
    logic [7:0]  ovr0, ovr1;

    int checks   = 0;
    int failures = 0;
    int log0[$];
    int log1[$];

    always #5 clk = ~clk;

    mux_scan_sequencer_if #(.WIDTH(32), .SELW(4)) if0 ();
    mux_scan_sequencer_if #(.WIDTH(32), .SELW(4)) if1 ();
    assign if0.out_ready = rdy0;
    assign if1.out_ready = rdy1;

    mux_scan_sequencer #(.WIDTH(32), .NCH(16), .SELW(4), .MUX_LAT(MUX_LAT), .SKIP_ZERO(0), .CNTW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .ch_mask_i(mask),
        .mux_sel_o(sel0), .mux_q_i(q0), .out_if(if0), .busy_o(busy0), .scan_done_o(done0),
        .overrun_cnt_o(ovr0));

    mux_scan_sequencer #(.WIDTH(32), .NCH(16), .SELW(4), .MUX_LAT(MUX_LAT), .SKIP_ZERO(1), .CNTW(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .ch_mask_i(mask),
        .mux_sel_o(sel1), .mux_q_i(q1), .out_if(if1), .busy_o(busy1), .scan_done_o(done1),
        .overrun_cnt_o(ovr1));

    // Registered channel mux in front of each instance.
    always_ff @(posedge clk) begin
        q0 <= tbl[sel0];
        q1 <= tbl[sel1];
    end

    // Reference model: a scan is a list of channels; each word is presented MUX_LAT+1 cycles after its select.
    logic [3:0]  m_sel   [2] = '{4'd0, 4'd0};
    logic        m_valid [2] = '{1'b0, 1'b0};
    logic [31:0] m_data  [2] = '{32'd0, 32'd0};
    logic [3:0]  m_chan  [2] = '{4'd0, 4'd0};
    logic        m_busy  [2] = '{1'b0, 1'b0};
    logic        m_done  [2] = '{1'b0, 1'b0};
    logic [7:0]  m_ovr   [2] = '{8'd0, 8'd0};
    logic        m_pres  [2] = '{1'b0, 1'b0};
    int          m_list  [2][16];
    int          m_head  [2] = '{0, 0};
    int          m_len   [2] = '{0, 0};
    int          m_cap   [2] = '{0, 0};
    int          cyc = 0;

    task automatic m_load(input int k);
        m_sel[k] = 4'(m_list[k][m_head[k]]);
        m_head[k]++;
        m_cap[k] = cyc + 1 + int'(MUX_LAT);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_sel[k] = '0; m_valid[k] = 1'b0; m_data[k] = '0; m_chan[k] = '0;
                m_busy[k] = 1'b0; m_done[k] = 1'b0; m_ovr[k] = '0; m_pres[k] = 1'b0;
                m_head[k] = 0; m_len[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic rdy;
                rdy = (k == 0) ? rdy0 : rdy1;
                m_done[k] = 1'b0;
                if (m_busy[k]) begin
                    if (abort) begin
                        m_busy[k] = 1'b0; m_valid[k] = 1'b0; m_pres[k] = 1'b0; m_head[k] = m_len[k];
                    end else begin
                        if (start && m_ovr[k] != 8'hFF) m_ovr[k] = m_ovr[k] + 8'd1;
                        if (m_pres[k]) begin
                            if (!m_valid[k] || rdy) begin
                                m_valid[k] = 1'b0;
                                m_pres[k]  = 1'b0;
                                if (m_head[k] < m_len[k]) m_load(k);
                                else begin
                                    m_busy[k] = 1'b0;
                                    m_done[k] = 1'b1;
                                end
                            end
                        end else if (cyc == m_cap[k]) begin
                            m_data[k]  = tbl[m_sel[k]];
                            m_chan[k]  = m_sel[k];
                            m_valid[k] = !(k == 1 && m_data[k] == 32'd0);
                            m_pres[k]  = 1'b1;
                        end
                    end
                end else if (start && !abort) begin
                    if (mask == 16'd0) m_done[k] = 1'b1;
                    else begin
                        m_len[k]  = 0;
                        m_head[k] = 0;
                        for (int i = 0; i < 16; i++) if (mask[i]) begin
                            m_list[k][m_len[k]] = i;
                            m_len[k]++;
                        end
                        m_load(k);
                        m_busy[k] = 1'b1;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic [3:0] s, input logic v, input logic [31:0] d,
                       input logic [3:0] c, input logic b, input logic dn, input logic [7:0] o);
        string p;
        p = (k == 0) ? "u0" : "u1";
        chk({p, ".mux_sel"}, 32'(s), 32'(m_sel[k]));
        chk({p, ".out_valid"}, 32'(v), 32'(m_valid[k]));
        chk({p, ".busy"}, 32'(b), 32'(m_busy[k]));
        chk({p, ".scan_done"}, 32'(dn), 32'(m_done[k]));
        chk({p, ".overrun_cnt"}, 32'(o), 32'(m_ovr[k]));
        if (m_valid[k]) begin
            chk({p, ".out_data"}, d, m_data[k]);
            chk({p, ".out_chan"}, 32'(c), 32'(m_chan[k]));
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        cmp(0, sel0, if0.out_valid, if0.out_data, if0.out_chan, busy0, done0, ovr0);
        cmp(1, sel1, if1.out_valid, if1.out_data, if1.out_chan, busy1, done1, ovr1);
    end

    initial forever begin
        @(posedge clk);
        if (if0.out_valid && if0.out_ready) log0.push_back(int'(if0.out_chan));
        if (if1.out_valid && if1.out_ready) log1.push_back(int'(if1.out_chan));
    end

    task automatic wait_valid0(input string nm);
        int n;
        n = 0;
        while (!if0.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".wait_valid"}, 32'(if0.out_valid), 32'd1);
    endtask

    task automatic default_tbl();
        for (int i = 0; i < 16; i++) tbl[i] = 32'(i) * 32'h1111_1111;
    endtask

    initial begin
        int ndone;
        int e2[4];
        int e3[2];
        int any;
        default_tbl();
        e2 = '{0, 5, 10, 15};
        e3 = '{5, 10};

        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy0), 32'd0);
        chk("rst.sel", 32'(sel0), 32'd0);
        chk("rst.valid", 32'(if0.out_valid), 32'd0);
        chk("rst.data", if0.out_data, 32'd0);
        chk("rst.done", 32'(done0), 32'd0);
        chk("rst.ovr", 32'(ovr0), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single channel, exact latency.
        rdy0 = 1'b1; rdy1 = 1'b1; mask = 16'h0001; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t1.sel_c1", 32'(sel0), 32'd0);
        chk("t1.busy_c1", 32'(busy0), 32'd1);
        @(negedge clk);
        chk("t1.valid_c2", 32'(if0.out_valid), 32'd0);
        @(negedge clk);
        chk("t1.valid_c3", 32'(if0.out_valid), 32'd1);
        chk("t1.data_c3", if0.out_data, 32'd0);
        chk("t1.chan_c3", 32'(if0.out_chan), 32'd0);
        @(negedge clk);
        chk("t1.done_c4", 32'(done0), 32'd1);
        chk("t1.valid_c4", 32'(if0.out_valid), 32'd0);
        @(negedge clk);
        chk("t1.done_c5", 32'(done0), 32'd0);
        chk("t1.busy_c5", 32'(busy0), 32'd0);

        // Sparse mask, ascending order, one done pulse.
        log0.delete(); log1.delete();
        mask = 16'h8421; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            ndone += int'(done0);
        end
        chk("t2.ndone", 32'(ndone), 32'd1);
        chk("t2.log0_size", 32'(log0.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2.log0_chan", (i < log0.size()) ? 32'(log0[i]) : 32'hFFFF_FFFF, 32'(e2[i]));
        chk("t2.log1_size", 32'(log1.size()), 32'd3);

        // Back-pressure holds the word.
        log0.delete(); log1.delete();
        tbl[0] = 32'hC0FF_EE00;
        rdy0 = 1'b0; rdy1 = 1'b0; mask = 16'h0003; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_valid0("t3");
        repeat (5) begin
            @(negedge clk);
            chk("t3.hold_data", if0.out_data, 32'hC0FF_EE00);
            chk("t3.hold_chan", 32'(if0.out_chan), 32'd0);
        end
        rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (10) @(negedge clk);
        chk("t3.log0_size", 32'(log0.size()), 32'd2);
        chk("t3.log0_second", (log0.size() > 1) ? 32'(log0[1]) : 32'hFFFF_FFFF, 32'd1);

        // Zero word skipped only by the SKIP_ZERO instance.
        log0.delete(); log1.delete();
        tbl[0] = 32'hA5A5_0000; tbl[2] = 32'd0; mask = 16'h0007; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        chk("t4.log1_size", 32'(log1.size()), 32'd2);
        chk("t4.log1_last", (log1.size() > 1) ? 32'(log1[1]) : 32'hFFFF_FFFF, 32'd1);
        chk("t4.log0_size", 32'(log0.size()), 32'd3);

        // Starts while busy are counted, not accepted.
        default_tbl(); tbl[0] = 32'h0000_0F0F;
        log1.delete();
        mask = 16'h0420; start = 1'b1;
        @(negedge clk); start = 1'b0; mask = 16'hFFFF;
        repeat (3) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        repeat (12) @(negedge clk);
        chk("t5.ovr0", 32'(ovr0), 32'd3);
        chk("t5.ovr1", 32'(ovr1), 32'd3);
        chk("t5.log1_size", 32'(log1.size()), 32'd2);
        for (int i = 0; i < 2; i++) chk("t5.log1_chan", (i < log1.size()) ? 32'(log1[i]) : 32'hFFFF_FFFF, 32'(e3[i]));

        // Abort during WAIT.
        mask = 16'h0010; start = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("t6.busy", 32'(busy0), 32'd0);
        chk("t6.valid", 32'(if0.out_valid), 32'd0);
        any = 0;
        repeat (6) begin
            @(negedge clk);
            any += int'(if0.out_valid) + int'(done0) + int'(busy0);
        end
        chk("t6.quiet", 32'(any), 32'd0);

        // Empty mask.
        mask = 16'h0000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t7.done", 32'(done0), 32'd1);
        chk("t7.busy", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("t7.done_end", 32'(done0), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            @(negedge clk);
            if (!m_busy[0] && !m_busy[1] && $urandom_range(0, 15) == 0) begin
                for (int i = 0; i < 16; i++) tbl[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            end
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 30) == 0);
            r = int'($urandom_range(0, 7));
            if (r == 0)      mask = 16'h0000;
            else if (r == 1) mask = 16'(1) << $urandom_range(0, 15);
            else             mask = 16'($urandom);
            rdy0 = ($urandom_range(0, 2) != 0);
            rdy1 = ($urandom_range(0, 2) != 0);
        end
        start = 1'b0; abort = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (60) @(negedge clk);
        chk("t8.ovr_sat", 32'(ovr0), 32'hFF);

        // Reset in the middle of OUT.
        tbl[6] = 32'h1234_5678;
        rdy0 = 1'b0; rdy1 = 1'b0; mask = 16'h0040; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_valid0("t9");
        #2 rst_n = 1'b0;
        #1;
        chk("t9.sel", 32'(sel0), 32'd0);
        chk("t9.valid", 32'(if0.out_valid), 32'd0);
        chk("t9.data", if0.out_data, 32'd0);
        chk("t9.chan", 32'(if0.out_chan), 32'd0);
        chk("t9.busy", 32'(busy0), 32'd0);
        chk("t9.ovr", 32'(ovr0), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
